regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug-side consumer of the register file's read port. On a start pulse it walks every register address from 0 to 2^ADDR_WIDTH−1, captures each word from the register file's combinational read output, and streams it as little-endian bytes over a valid/ready byte interface to the debug UART transmitter. It sits between the register file (read port 2 is muxed to this block while the core is halted) and the UART TX FIFO.

## Interface
- ADDR_WIDTH, 5, register address width; dump covers 2^ADDR_WIDTH registers
- DATA_WIDTH, 32, register width; must be a multiple of 8
- clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  dump request; sampled only in IDLE
- o_busy  output  1  high in LOAD and SEND
- o_done  output  1  one-cycle pulse after the final byte is accepted
- o_rf_addr  output  ADDR_WIDTH  register file read address
- i_rf_data  input  DATA_WIDTH  register file read data (combinational from o_rf_addr)
- o_tx_data  output  8  byte to transmitter
- o_tx_valid  output  1  byte valid
- i_tx_ready  input  1  transmitter accepts byte

## Operation
- BYTES = DATA_WIDTH/8; byte counter width = max(1, clog2(BYTES)).
- States: IDLE, LOAD, SEND, DONE.
- IDLE: o_rf_addr=0, o_tx_valid=0. i_start=1 → word index cleared to 0, go to LOAD.
- LOAD: o_rf_addr=word index; at the clock edge, i_rf_data is latched into the shift register and the byte counter is cleared; go to SEND.
- SEND: o_tx_valid=1, o_tx_data=shift[7:0]. When o_tx_valid && i_tx_ready: shift right by 8, byte counter +1. On acceptance of byte BYTES−1: if word index == 2^ADDR_WIDTH−1 → DONE, else word index +1 → LOAD.
- DONE: o_done=1 for exactly one cycle → IDLE.
- Handshake: once o_tx_valid is asserted, o_tx_data is held stable until accepted; valid never drops without acceptance except on reset.
- i_start outside IDLE (including DONE) is ignored; no queuing.
- Word index wraps naturally at the final register and is not used past it; no extra read is issued.
- Register 0 is dumped like any other; the register file returns 0 for it.
- Byte order: LSB first within each word; words in ascending address order.

## Timing
- Reset: state=IDLE, o_busy=0, o_done=0, o_tx_valid=0, o_tx_data=0, o_rf_addr=0, word index, byte counter and shift register = 0.
- i_rst has priority over every event; asserted mid-dump, it returns the block to IDLE on the next edge and drops o_tx_valid without completing the byte.
- i_start sampled at edge 0 → LOAD during cycle 1 (o_busy=1) → first byte valid in cycle 2.
- With i_tx_ready held high: per register, 1 LOAD + BYTES SEND cycles. For defaults, register k is in LOAD at cycle 1+5k and in SEND at cycles 2+5k to 5+5k. The last byte is accepted at cycle 160, and o_done=1 in cycle 161.
- Each cycle with i_tx_ready=0 in SEND extends total latency by one cycle.
- i_rf_data is consumed only at the LOAD edge. Register writes occurring during SEND do not affect the word in flight.

## Structure
- Shared debug package: state encoding constants (IDLE/LOAD/SEND/DONE), BYTES derivation, and the byte-interface width (8).
- One natural sub-module: word_serializer. It takes a DATA_WIDTH parallel load with a load strobe, outputs a valid/ready byte stream, and provides a last-byte flag. The top FSM owns the word index and the done/busy signals.

## Test plan
- Reset then idle: no i_start → o_tx_valid=0, o_busy=0, o_rf_addr=0 for 20 cycles.
- Full dump, ready tied high, register model xN = 0x11223300+N (x0=0): 128 bytes arrive in order 00,00,00,00, 01,33,22,11, …, 1F,33,22,11. o_done pulses exactly once, at cycle 161.
- Backpressure: i_tx_ready random 30% duty → same 128-byte sequence. o_tx_data stays stable whenever valid=1 and ready=0; no byte is lost or duplicated.
- i_start re-pulsed during SEND and during DONE → ignored. Exactly 128 bytes and one o_done.
- Reset at cycle 50 of a dump → next cycle IDLE, o_tx_valid=0. A subsequent i_start produces a complete, correct 128-byte dump.
- Register write to x5 (0xDEADBEEF) during the SEND phase of x5 → the old x5 bytes are sent. A second dump returns EF,BE,AD,DE for x5.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump path: FSM state encoding,
// byte-interface width and the bytes-per-word derivation.
package regfile_dump_pkg;

  localparam int TX_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of transmit bytes in one register word.
  function automatic int bytes_per_word(input int data_width);
    return data_width / TX_WIDTH;
  endfunction

  // Byte counter width; at least one bit even for single-byte words.
  function automatic int byte_cnt_width(input int data_width);
    int b;
    b = data_width / TX_WIDTH;
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/regfile_dump_word_serializer.sv
// Parallel-load word serializer: a load strobe captures one word, which is
// then emitted LSB byte first over a valid/ready byte stream.
// Handshake: a byte moves when o_valid && i_ready at a rising edge; once
// o_valid is high, o_data holds until that happens, and o_valid only falls
// after the last byte of the word is accepted (or on reset).
module regfile_dump_word_serializer
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [TX_WIDTH-1:0]   o_data,
  output logic                  o_valid,
  output logic                  o_last
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam int CW    = byte_cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;

  // Next-state: load a fresh word, or advance one byte per accepted transfer.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_data;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      shift_d = shift_q >> TX_WIDTH;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST_CNT) valid_d = 1'b0;
    end
  end

  // Serializer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = shift_q[TX_WIDTH-1:0];
  assign o_valid = valid_q;
  assign o_last  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/regfile_dump.sv
// Register-file dump engine: on i_start, reads registers 0..2^ADDR_WIDTH-1
// one at a time and streams each word LSB byte first to the debug UART.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  output logic [TX_WIDTH-1:0]   o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic ser_load;
  logic ser_valid;
  logic ser_last;
  logic word_sent;

  assign ser_load  = (state_q == ST_LOAD);
  assign word_sent = ser_valid && i_tx_ready && ser_last;

  // Next-state and registered-output decode for the dump sequencer.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          word_idx_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (word_sent) begin
          if (word_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            state_d    = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_SEND);
    done_d    = (state_d == ST_DONE);
    rf_addr_d = (state_d == ST_LOAD) ? word_idx_d : '0;
  end

  // Sequencer state and outputs, synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      rf_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      rf_addr_q  <= rf_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  regfile_dump_word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_load (ser_load),
    .i_data (i_rf_data),
    .i_ready(i_tx_ready),
    .o_data (o_tx_data),
    .o_valid(ser_valid),
    .o_last (ser_last)
  );

  assign o_tx_valid = ser_valid;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rf_addr  = rf_addr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: register file modelled as an array read
// combinationally at o_rf_addr; outputs sampled on the falling edge.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic [4:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  logic [31:0] rf [32];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_count;
  int done_cycle;
  int stall_err;
  int post_done_activity;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign i_rf_data = rf[o_rf_addr];

  regfile_dump dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rf_addr (o_rf_addr),
    .i_rf_data (i_rf_data),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready)
  );

  // ---------------- driver tasks ----------------
  task automatic set_rf_default();
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : (32'h11223300 + 32'(i));
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(rf[i][8*b +: 8]);
  endtask

  // Start a dump and run it, collecting accepted bytes. Cycle 1 is the
  // cycle after the edge that samples i_start.
  task automatic run_dump(input int ready_pct, input int max_cyc,
                          input bit repulse, input bit wr5);
    logic       prev_stall;
    logic [7:0] prev_data;
    got_q.delete();
    done_count = 0;
    done_cycle = -1;
    stall_err = 0;
    post_done_activity = 0;
    prev_stall = 1'b0;
    prev_data = 8'h0;
    @(negedge clk);
    i_start = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_tx_ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < ready_pct);
      if (repulse && (cyc == 16 || cyc == 20)) i_start = 1'b1;
      if (wr5 && cyc == 28) rf[5] = 32'hDEADBEEF;
      if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stall_err++;
      if (done_cycle >= 0 && (o_busy || o_tx_valid)) post_done_activity++;
      if (o_done) begin
        done_count++;
        if (done_cycle < 0) begin
          done_cycle = cyc;
          if (repulse) i_start = 1'b1;
        end
      end
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      if (done_cycle >= 0 && cyc >= done_cycle + 10) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_tx_valid, o_busy, o_done} !== 3'b000 || o_rf_addr !== 5'd0 || o_tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid/busy/done=%b addr=%0d data=%h, required 000 0 00",
               {o_tx_valid, o_busy, o_done}, o_rf_addr, o_tx_data);
    end
    i_rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_rf_addr !== 5'd0) begin
        n_fail++;
        $display("FAIL idle_quiet c%0d: valid=%b busy=%b addr=%0d, required 0 0 0",
                 c, o_tx_valid, o_busy, o_rf_addr);
      end
    end
  endtask

  task automatic test_full_dump();
    set_rf_default();
    build_exp();
    run_dump(100, 400, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 128) begin
      n_fail++;
      $display("FAIL full_dump count: got %0d bytes, required 128", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_dump byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() >= 128) begin
      n_checks++;
      if ({got_q[0], got_q[4], got_q[5], got_q[7], got_q[124], got_q[127]} !== 48'h00_01_33_11_1F_11) begin
        n_fail++;
        $display("FAIL full_dump vectors: got %h %h %h %h %h %h, required 00 01 33 11 1f 11",
                 got_q[0], got_q[4], got_q[5], got_q[7], got_q[124], got_q[127]);
      end
    end
    n_checks++;
    if (done_count != 1 || done_cycle != 161) begin
      n_fail++;
      $display("FAIL full_dump done: count=%0d cycle=%0d, required 1 at 161", done_count, done_cycle);
    end
    n_checks++;
    if (post_done_activity != 0) begin
      n_fail++;
      $display("FAIL full_dump after_done: %0d busy/valid cycles, required 0", post_done_activity);
    end
  endtask

  task automatic test_backpressure();
    set_rf_default();
    build_exp();
    run_dump(30, 3000, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 128) begin
      n_fail++;
      $display("FAIL backpressure count: got %0d bytes, required 128", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL backpressure byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_err != 0) begin
      n_fail++;
      $display("FAIL backpressure stable: %0d unstable stall cycles, required 0", stall_err);
    end
    n_checks++;
    if (done_count != 1 || done_cycle < 161) begin
      n_fail++;
      $display("FAIL backpressure done: count=%0d cycle=%0d, required 1 at >=161", done_count, done_cycle);
    end
  endtask

  task automatic test_start_repulse();
    set_rf_default();
    build_exp();
    run_dump(100, 400, 1'b1, 1'b0);
    n_checks++;
    if (got_q.size() != 128) begin
      n_fail++;
      $display("FAIL repulse count: got %0d bytes, required 128", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL repulse byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_count != 1 || done_cycle != 161 || post_done_activity != 0) begin
      n_fail++;
      $display("FAIL repulse done: count=%0d cycle=%0d after=%0d, required 1 161 0",
               done_count, done_cycle, post_done_activity);
    end
  endtask

  task automatic test_reset_mid_dump();
    set_rf_default();
    build_exp();
    run_dump(100, 50, 1'b0, 1'b0);
    i_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_tx_valid, o_busy, o_done} !== 3'b000 || o_rf_addr !== 5'd0 || o_tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset state: valid/busy/done=%b addr=%0d data=%h, required 000 0 00",
               {o_tx_valid, o_busy, o_done}, o_rf_addr, o_tx_data);
    end
    i_rst = 1'b0;
    run_dump(100, 400, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 128 || done_count != 1 || done_cycle != 161) begin
      n_fail++;
      $display("FAIL mid_reset redump: bytes=%0d done=%0d at %0d, required 128 1 161",
               got_q.size(), done_count, done_cycle);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_reset byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_write_during_send();
    set_rf_default();
    build_exp();
    run_dump(100, 400, 1'b0, 1'b1);
    n_checks++;
    if (got_q.size() != 128) begin
      n_fail++;
      $display("FAIL wr_send count: got %0d bytes, required 128", got_q.size());
    end else if ({got_q[20], got_q[21], got_q[22], got_q[23]} !== 32'h05_33_22_11) begin
      n_fail++;
      $display("FAIL wr_send x5_old: got %h %h %h %h, required 05 33 22 11",
               got_q[20], got_q[21], got_q[22], got_q[23]);
    end
    build_exp();
    run_dump(100, 400, 1'b0, 1'b0);
    n_checks++;
    if (got_q.size() != 128) begin
      n_fail++;
      $display("FAIL wr_send2 count: got %0d bytes, required 128", got_q.size());
    end else if ({got_q[20], got_q[21], got_q[22], got_q[23]} !== 32'hEF_BE_AD_DE) begin
      n_fail++;
      $display("FAIL wr_send2 x5_new: got %h %h %h %h, required ef be ad de",
               got_q[20], got_q[21], got_q[22], got_q[23]);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wr_send2 byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_rf_default();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_repulse();
    test_reset_mid_dump();
    test_write_during_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
